mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the data-memory side of the single-cycle core.
- Consumes the core's store stream (MemWrite, ALUResult as address, WriteData) and returns read data for its register window.
- Buffers bytes in a FIFO and serialises them 8N1 on a tx pin.
- The top-level ReadData mux selects rdata when sel is high, otherwise data-memory output.

---
 rtl/mmio_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the core's data-memory port.
// Registers: TXDATA (push), STATUS (flags/count, W1C overflow), DIV (clocks per bit).
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq,
    output logic [1:0]  state_dbg
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [15:0]   cnt;
    logic [15:0]   period;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [15:0]   div;
    logic          overflow;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    mem [FIFO_DEPTH];

    logic [1:0]    off;
    logic          wr;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          bit_done;
    logic [15:0]   p_next;
    logic [5:0]    count6;
    logic          unused_bits;

    assign unused_bits = ^{ALUResult[1:0], WriteData[31:16]};

    assign sel      = (ALUResult[31:4] == BASE_ADDR[31:4]);
    assign off      = ALUResult[3:2];
    assign wr       = MemWrite & sel;
    assign push     = wr & (off == 2'd0);
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign bit_done = (cnt == period - 16'd1);
    assign p_next   = (div == 16'd0) ? 16'd1 : div;
    assign count6   = 6'(count);
    assign state_dbg = state;

    // The shifter takes a byte when idle, or at the very end of a stop bit so frames abut.
    assign pop     = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
    assign push_ok = push & (~full | pop);

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                2'd1:    rdata = {22'd0, count6, overflow, busy, empty, full};
                2'd2:    rdata = {16'd0, div};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div      <= DEFAULT_DIV;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & full & ~pop)
                overflow <= 1'b1;
            else if (wr & (off == 2'd1) & WriteData[3])
                overflow <= 1'b0;
            if (wr & (off == 2'd2)) div <= WriteData[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        period <= p_next;
                        cnt    <= '0;
                        state  <= START;
                        tx     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (pop) begin
                            shift  <= mem[rd_ptr];
                            period <= p_next;
                            state  <= START;
                            tx     <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b1;
        else      irq <= empty & ~busy;
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: reset, single/back-to-back frames, overflow, decode, mid-frame reset.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;
    logic [1:0]  state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    mmio_uart_tx dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .sel       (sel),
        .rdata     (rdata),
        .tx        (tx),
        .irq       (irq),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        ALUResult = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        cyc();
        MemWrite  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ALUResult = addr;
        MemWrite  = 1'b0;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        logic [9:0]  frame_a5;
        logic [19:0] seq_b2b;
        int          busy_cnt;
        int          low_cnt;

        frame_a5 = 10'b1_10100101_0;
        seq_b2b  = {10'b1_00001111_0, 10'b1_01010101_0};

        rst = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();

        // Reset / idle
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd1);
        rd_check("reset_status", BASE + 32'd4, 32'h0000_0002);
        rd_check("reset_div", BASE + 32'd8, 32'd16);
        rd_check("txdata_reads0", BASE, 32'd0);
        rd_check("rsvd_reads0", BASE + 32'd12, 32'd0);

        // Single frame, DIV=4
        wr(BASE + 32'd8, 32'd4);
        rd_check("div4", BASE + 32'd8, 32'd4);
        wr(BASE, 32'h0000_00A5);
        check("sf_tx_before", {31'd0, tx}, 32'd1);
        check("sf_irq_before", {31'd0, irq}, 32'd1);
        rd_check("sf_status_queued", BASE + 32'd4, 32'h0000_0010);
        cyc();
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            ALUResult = BASE + 32'd4;
            #1;
            check($sformatf("sf_tx_c%0d", c), {31'd0, tx}, {31'd0, frame_a5[c/4]});
            if (rdata[2]) busy_cnt++;
            if (c == 0) begin
                check("sf_irq_busy", {31'd0, irq}, 32'd0);
                check("sf_status_busy", rdata, 32'h0000_0006);
            end
            cyc();
        end
        check("sf_busy_cycles", busy_cnt, 32'd40);
        rd_check("sf_status_done", BASE + 32'd4, 32'h0000_0002);
        check("sf_irq_lag", {31'd0, irq}, 32'd0);
        cyc();
        check("sf_irq_back", {31'd0, irq}, 32'd1);

        // Back-to-back frames, DIV=2
        wr(BASE + 32'd8, 32'd2);
        wr(BASE, 32'h0000_0055);
        rd_check("b2b_count_a", BASE + 32'd4, 32'h0000_0010);
        wr(BASE, 32'h0000_000F);
        rd_check("b2b_count_b", BASE + 32'd4, 32'h0000_0014);
        for (int c = 0; c < 40; c++) begin
            ALUResult = BASE + 32'd4;
            #1;
            check($sformatf("b2b_tx_c%0d", c), {31'd0, tx}, {31'd0, seq_b2b[c/2]});
            if (c == 19) check("b2b_status_c19", rdata, 32'h0000_0014);
            if (c == 20) check("b2b_status_c20", rdata, 32'h0000_0006);
            cyc();
        end
        rd_check("b2b_status_done", BASE + 32'd4, 32'h0000_0002);

        // Overflow, DIV=100
        wr(BASE + 32'd8, 32'd100);
        for (int i = 0; i < 10; i++) wr(BASE, 32'h30 + i);
        rd_check("ovf_status", BASE + 32'd4, 32'h0000_008D);
        check("ovf_tx_start", {31'd0, tx}, 32'd0);
        wr(BASE + 32'd4, 32'h0000_0008);
        rd_check("ovf_cleared", BASE + 32'd4, 32'h0000_0085);

        // Decode
        wr(BASE + 32'd12, 32'h0000_00FF);
        wr(BASE + 32'd16, 32'h0000_00AB);
        rd_check("dec_status_kept", BASE + 32'd4, 32'h0000_0085);
        rd_check("dec_div_kept", BASE + 32'd8, 32'd100);
        rd_check("dec_rsvd", BASE + 32'd12, 32'd0);
        check("dec_rsvd_sel", {31'd0, sel}, 32'd1);
        rd_check("dec_outside", BASE + 32'd16, 32'd0);
        check("dec_outside_sel", {31'd0, sel}, 32'd0);
        rd_check("dec_unaligned", BASE + 32'd5, 32'h0000_0085);

        // Reset to a clean state, then reset in the middle of DATA bit 3
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rd_check("rst2_status", BASE + 32'd4, 32'h0000_0002);
        rd_check("rst2_div", BASE + 32'd8, 32'd16);
        wr(BASE, 32'h0000_00A5);
        cyc();
        repeat (72) cyc();
        check("mid_tx_bit3", {31'd0, tx}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_tx_async", {31'd0, tx}, 32'd1);
        cyc();
        cyc();
        rst = 1'b1;
        rd_check("mid_status", BASE + 32'd4, 32'h0000_0002);
        rd_check("mid_div", BASE + 32'd8, 32'd16);
        low_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (!tx) low_cnt++;
            cyc();
        end
        check("mid_no_frame", low_cnt, 32'd0);
        check("mid_irq", {31'd0, irq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
